// File: rtl/layer_norm_row_sequencer_pkg.sv
// Shared definitions for the layer-norm row sequencer and layer_norm_top.
// Contents:
//   - Default row length and Q-format widths/fraction bits of the x, y and
//     gamma/beta vectors exchanged with layer_norm_top.
//   - Sequencer state encoding (LOAD -> START -> WAIT -> DRAIN -> LOAD).
package layer_norm_row_sequencer_pkg;

    localparam int LN_D_MODEL      = 64;
    localparam int LN_X_WIDTH      = 16;   // Q5.10
    localparam int LN_X_FRAC       = 10;
    localparam int LN_Y_WIDTH      = 16;   // Q5.10
    localparam int LN_Y_FRAC       = 10;
    localparam int LN_PARAM_WIDTH  = 8;    // Q1.6
    localparam int LN_PARAM_FRAC   = 6;
    localparam int LN_DONE_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/layer_norm_row_sequencer.sv
// Initiator side of the layer_norm_top start/done interface.
// Collects one row of D_MODEL signed elements from a valid/ready stream into
// the flat x vector, pulses start, waits for done (bounded by DONE_TIMEOUT),
// captures the flat y vector and replays it on an output valid/ready stream.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   input element stream
//   gamma_cfg, beta_cfg             static parameters, forwarded unregistered
//   ln_start_out, ln_x_flat_out     start pulse and packed row to layer_norm_top
//   ln_gamma_out, ln_beta_out       forwarded gamma/beta
//   ln_y_flat_in, ln_done_in        normalized row and result-valid from layer_norm_top
//   out_valid/out_ready/out_data/out_last  output element stream
//   err_len_out                     1-cycle pulse: row length != D_MODEL
//   err_timeout_out                 1-cycle pulse: done not seen in time
//   busy_out                        high in any state except LOAD
module layer_norm_row_sequencer
    import layer_norm_row_sequencer_pkg::*;
#(
    parameter int D_MODEL      = LN_D_MODEL,
    parameter int X_WIDTH      = LN_X_WIDTH,
    parameter int Y_WIDTH      = LN_Y_WIDTH,
    parameter int PARAM_WIDTH  = LN_PARAM_WIDTH,
    parameter int DONE_TIMEOUT = LN_DONE_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [X_WIDTH-1:0]        in_data,
    input  logic                             in_last,
    input  logic [D_MODEL*PARAM_WIDTH-1:0]   gamma_cfg,
    input  logic [D_MODEL*PARAM_WIDTH-1:0]   beta_cfg,
    output logic                             ln_start_out,
    output logic [D_MODEL*X_WIDTH-1:0]       ln_x_flat_out,
    output logic [D_MODEL*PARAM_WIDTH-1:0]   ln_gamma_out,
    output logic [D_MODEL*PARAM_WIDTH-1:0]   ln_beta_out,
    input  logic [D_MODEL*Y_WIDTH-1:0]       ln_y_flat_in,
    input  logic                             ln_done_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [Y_WIDTH-1:0]        out_data,
    output logic                             out_last,
    output logic                             err_len_out,
    output logic                             err_timeout_out,
    output logic                             busy_out
);

    localparam int IDX_W = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
    localparam int TMR_W = $clog2(DONE_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D_MODEL - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(DONE_TIMEOUT - 1);

    seq_state_t                 state;
    seq_state_t                 state_nxt;
    logic [IDX_W-1:0]           idx;
    logic [TMR_W-1:0]           timer;
    logic [D_MODEL*X_WIDTH-1:0] x_flat;
    logic [D_MODEL*Y_WIDTH-1:0] y_flat;
    logic                       accept;
    logic                       row_end;
    logic                       tmo_hit;

    // A row closes either on the D_MODEL-th beat or on an early in_last.
    assign accept  = (state == ST_LOAD) && in_valid;
    assign row_end = accept && ((idx == LAST_IDX) || in_last);
    // Done has priority over the timeout in the same cycle.
    assign tmo_hit = (state == ST_WAIT) && !ln_done_in && (timer == TMO_LAST);

    assign ln_x_flat_out = x_flat;
    assign ln_gamma_out  = gamma_cfg;
    assign ln_beta_out   = beta_cfg;
    assign out_data      = y_flat[idx*Y_WIDTH +: Y_WIDTH];
    assign busy_out      = (state != ST_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        in_ready        = 1'b0;
        ln_start_out    = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        err_len_out     = 1'b0;
        err_timeout_out = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (row_end) begin
                    state_nxt = ST_START;
                    // Full row without in_last, or in_last before the row is full.
                    err_len_out = (idx == LAST_IDX) ? !in_last : 1'b1;
                end
            end
            ST_START: begin
                ln_start_out = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (ln_done_in) begin
                    state_nxt = ST_DRAIN;
                end else if (tmo_hit) begin
                    err_timeout_out = 1'b1;
                    state_nxt       = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                if (out_ready && (idx == LAST_IDX)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Row buffers, element index and done timer. Buffers are cleared by reset
    // so that nothing from an aborted row can ever be replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            timer  <= '0;
            x_flat <= '0;
            y_flat <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        x_flat[idx*X_WIDTH +: X_WIDTH] <= in_data;
                        if (row_end) begin
                            idx <= '0;
                            // Short row: pad the remainder with zeros in one go.
                            for (int i = 0; i < D_MODEL; i++) begin
                                if (i > int'(idx)) begin
                                    x_flat[i*X_WIDTH +: X_WIDTH] <= '0;
                                end
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    timer <= '0;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (ln_done_in) begin
                        y_flat <= ln_y_flat_in;
                        idx    <= '0;
                    end else if (tmo_hit) begin
                        idx <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_norm_row_sequencer.sv
// Self-checking bench for layer_norm_row_sequencer.
// A behavioural layer_norm_top responder answers each start pulse (ideal
// layer-norm maths, random rows, or silence), a row-splitting reference
// model predicts every packed x row and length error, and a monitor checks
// the output stream against the rows the responder handed back.
module tb_layer_norm_row_sequencer;
    import layer_norm_row_sequencer_pkg::*;

    localparam int D   = 64;
    localparam int XW  = 16;
    localparam int YW  = 16;
    localparam int PW  = 8;
    localparam int TMO = 4096;

    typedef logic [D*XW-1:0] xrow_t;
    typedef logic [D*YW-1:0] yrow_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XW-1:0]   in_data;
    logic            in_last;
    logic [D*PW-1:0] gamma_cfg;
    logic [D*PW-1:0] beta_cfg;
    logic            ln_start_out;
    xrow_t           ln_x_flat_out;
    logic [D*PW-1:0] ln_gamma_out;
    logic [D*PW-1:0] ln_beta_out;
    yrow_t           ln_y_flat_in;
    logic            ln_done_in;
    logic            out_valid;
    logic            out_ready;
    logic [YW-1:0]   out_data;
    logic            out_last;
    logic            err_len_out;
    logic            err_timeout_out;
    logic            busy_out;

    layer_norm_row_sequencer #(
        .D_MODEL(D), .X_WIDTH(XW), .Y_WIDTH(YW), .PARAM_WIDTH(PW), .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .gamma_cfg(gamma_cfg), .beta_cfg(beta_cfg),
        .ln_start_out(ln_start_out), .ln_x_flat_out(ln_x_flat_out),
        .ln_gamma_out(ln_gamma_out), .ln_beta_out(ln_beta_out),
        .ln_y_flat_in(ln_y_flat_in), .ln_done_in(ln_done_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err_len_out(err_len_out), .err_timeout_out(err_timeout_out), .busy_out(busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard state
    xrow_t          exp_rows[$];
    logic [YW:0]    exp_out[$];     // {last, data}
    logic [YW-1:0]  out_log[$];
    logic [XW-1:0]  stim_d[$];
    logic           stim_l[$];
    int exp_err_len = 0, exp_starts = 0, exp_tmo = 0;
    int n_start = 0, n_err_len = 0, n_tmo = 0;
    int start_cyc = 0, tmo_cyc = 0;
    int ln_mode = 0;            // 0 random y, 1 ideal layer-norm, 2 never done
    int resp_busy = 0;
    int rdy_pct = 100, gap_pct = 0;
    int poke_req = 0, poke_ack = 0;
    xrow_t resp_x, resp_exp;
    yrow_t resp_y;
    int resp_delay, mism;

    // Ideal layer norm in real arithmetic, rounded to Q5.10 with saturation.
    function automatic yrow_t ln_ref(input xrow_t xf, input logic [D*PW-1:0] g,
                                     input logic [D*PW-1:0] b);
        real xv[D];
        real mean, vr, sd, v;
        int r;
        yrow_t yf;
        mean = 0.0;
        for (int i = 0; i < D; i++) begin
            xv[i] = $itor($signed(xf[i*XW +: XW])) / 1024.0;
            mean  = mean + xv[i];
        end
        mean = mean / D;
        vr = 0.0;
        for (int i = 0; i < D; i++) vr = vr + (xv[i] - mean) * (xv[i] - mean);
        vr = vr / D;
        sd = $sqrt(vr + 1.0e-5);
        for (int i = 0; i < D; i++) begin
            v = (xv[i] - mean) / sd * ($itor($signed(g[i*PW +: PW])) / 64.0)
                + $itor($signed(b[i*PW +: PW])) / 64.0;
            v = v * 1024.0;
            r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            yf[i*YW +: YW] = 16'(r);
        end
        return yf;
    endfunction

    // Behavioural layer_norm_top
    initial begin
        ln_done_in   = 1'b0;
        ln_y_flat_in = '0;
        forever begin
            @(negedge clk);
            if (poke_req != poke_ack) begin
                ln_y_flat_in = {D{16'h5a5a}};
                ln_done_in   = 1'b1;
                @(negedge clk);
                ln_done_in = 1'b0;
                poke_ack   = poke_req;
            end else if (ln_start_out && !rst) begin
                resp_busy = 1;
                n_start++;
                start_cyc = cyc;
                resp_x    = ln_x_flat_out;
                if (exp_rows.size() == 0) begin
                    check_val("unexpected_start", 1, 0);
                end else begin
                    resp_exp = exp_rows.pop_front();
                    mism = 0;
                    for (int i = 0; i < D; i++)
                        if (resp_x[i*XW +: XW] !== resp_exp[i*XW +: XW]) mism++;
                    check_val("x_row_bad_elems", mism, 0);
                end
                @(negedge clk);
                check_val("start_one_cycle", ln_start_out, 0);
                if (ln_mode != 2) begin
                    resp_delay = (ln_mode == 1) ? 20 : $urandom_range(1, 30);
                    if (ln_mode == 1) resp_y = ln_ref(resp_x, gamma_cfg, beta_cfg);
                    else for (int i = 0; i < D; i++) resp_y[i*YW +: YW] = 16'($urandom);
                    repeat (resp_delay - 1) @(negedge clk);
                    for (int i = 0; i < D; i++) exp_out.push_back({(i == D-1), resp_y[i*YW +: YW]});
                    ln_y_flat_in = resp_y;
                    ln_done_in   = 1'b1;
                    @(negedge clk);
                    ln_done_in   = 1'b0;
                    ln_y_flat_in = ~resp_y;
                    check_val("done_to_valid", out_valid, 1);
                end
                resp_busy = 0;
            end
        end
    end

    // Output-side monitor
    logic          prev_stall = 1'b0;
    logic [YW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [YW:0]   mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (err_len_out) n_err_len++;
                if (err_timeout_out) begin
                    n_tmo++;
                    tmo_cyc = cyc;
                end
                if (prev_stall) begin
                    check_val("hold_valid", out_valid, 1);
                    check_val("hold_data", out_data, prev_data);
                    check_val("hold_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        check_val("unexpected_out", 1, 0);
                    end else begin
                        mon_e = exp_out.pop_front();
                        check_val("out_data", out_data, mon_e[YW-1:0]);
                        check_val("out_last", out_last, mon_e[YW]);
                        out_log.push_back(out_data);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input logic [XW-1:0] d, input logic l, input bit ends);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 20000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20000) check_val("in_ready_wait", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ends) begin
            @(negedge clk);
            check_val("start_latency", ln_start_out, 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Reference row splitting: a row closes at D beats or at in_last; it is a
    // length error unless it closes at exactly D beats with in_last set.
    task automatic send_stream();
        xrow_t row = '0;
        int cnt = 0;
        bit ends[$];
        for (int k = 0; k < stim_d.size(); k++) begin
            row[cnt*XW +: XW] = stim_d[k];
            cnt++;
            if (cnt == D || stim_l[k]) begin
                if (!(cnt == D && stim_l[k])) exp_err_len++;
                exp_rows.push_back(row);
                exp_starts++;
                row = '0;
                cnt = 0;
                ends.push_back(1'b1);
            end else begin
                ends.push_back(1'b0);
            end
        end
        for (int k = 0; k < stim_d.size(); k++) begin
            send_beat(stim_d[k], stim_l[k], ends[k]);
            if ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
        end
        stim_d.delete();
        stim_l.delete();
    endtask

    task automatic make_stim(input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            stim_d.push_back(16'($urandom));
            stim_l.push_back(k == last_at);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy_out || resp_busy != 0 || exp_out.size() != 0 || exp_rows.size() != 0)
               && guard < 20000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20000) check_val("idle_wait", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_starts"}, n_start, exp_starts);
        check_val({tag, "_err_len"}, n_err_len, exp_err_len);
        check_val({tag, "_err_tmo"}, n_tmo, exp_tmo);
    endtask

    task automatic check_idle_state(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 1);
        check_val({tag, "_busy"}, busy_out, 0);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_start"}, ln_start_out, 0);
        check_val({tag, "_x_nonzero"}, |ln_x_flat_out, 0);
        check_val({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        for (int i = 0; i < D; i++) gamma_cfg[i*PW +: PW] = 8'd64;
        beta_cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_state("reset");
        check_val("reset_err_len", err_len_out, 0);
        check_val("reset_err_tmo", err_timeout_out, 0);
        check_val("reset_out_last", out_last, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1) alternating 2.0 / 0.5 row through an ideal layer norm
        ln_mode = 1;
        out_log.delete();
        for (int k = 0; k < D; k++) begin
            stim_d.push_back((k % 2 == 0) ? 16'h0800 : 16'h0200);
            stim_l.push_back(k == D-1);
        end
        send_stream();
        wait_idle();
        check_val("t1_x0", resp_x[15:0], 16'h0800);
        check_val("t1_x1", resp_x[31:16], 16'h0200);
        check_val("t1_beats", out_log.size(), D);
        if (out_log.size() >= 2) begin
            check_val("t1_y0", out_log[0], 16'h0400);
            check_val("t1_y1", out_log[1], 16'hFC00);
        end
        check_counts("t1");

        // 2) short row: in_last on beat 10
        ln_mode = 0;
        make_stim(11, 10);
        send_stream();
        wait_idle();
        check_counts("t2");

        // 3) 70 beats, in_last only on the final one
        make_stim(70, 69);
        send_stream();
        wait_idle();
        check_counts("t3");

        // 4) done never arrives
        ln_mode = 2;
        make_stim(D, D-1);
        send_stream();
        exp_tmo++;
        guard = 0;
        while (n_tmo != exp_tmo && guard < 20000) begin
            guard++;
            @(posedge clk);
        end
        check_val("t4_tmo_seen", n_tmo, exp_tmo);
        check_val("t4_tmo_delay", tmo_cyc - start_cyc, TMO);
        @(negedge clk);
        check_val("t4_in_ready_after", in_ready, 1);
        poke_req++;
        guard = 0;
        while (poke_ack != poke_req && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        check_val("t4_stray_done_busy", busy_out, 0);
        check_val("t4_stray_done_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check_counts("t4");

        // 5) back-pressure and input gaps, random gamma/beta
        ln_mode = 0;
        rdy_pct = 30;
        gap_pct = 20;
        for (int i = 0; i < D; i++) begin
            gamma_cfg[i*PW +: PW] = 8'($urandom);
            beta_cfg[i*PW +: PW]  = 8'($urandom);
        end
        #1;
        check_val("t5_gamma_pass", ln_gamma_out == gamma_cfg, 1);
        check_val("t5_beta_pass", ln_beta_out == beta_cfg, 1);
        make_stim(D, D-1);
        make_stim(D, D-1);
        send_stream();
        wait_idle();
        check_counts("t5");
        rdy_pct = 100;
        gap_pct = 0;

        // 6) reset while waiting for done, then a fresh row
        ln_mode = 2;
        make_stim(D, D-1);
        send_stream();
        repeat (10) @(posedge clk);
        #1;
        check_val("t6_busy_wait", busy_out, 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_state("t6_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        ln_mode = 0;
        make_stim(D, D-1);
        send_stream();
        wait_idle();
        check_counts("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
